mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 34 +++
 rtl/mem_arbiter_rr_arb2.sv | 40 ++++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM state and
// owner encodings, default timing parameters and the latched transaction.
package mem_arbiter_pkg;

  localparam int DEF_OUT_CYCLES = 5;
  localparam int DEF_LINE_WORDS = 4;
  localparam int WORD_BYTES     = 4;
  localparam int BEAT_W         = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Everything captured from the winning requester at grant time.
  typedef struct packed {
    owner_t      owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  // Byte address of the first word of the line containing addr.
  function automatic logic [31:0] line_base(input logic [31:0] addr,
                                            input int          line_words);
    return addr & ~(32'(line_words * WORD_BYTES) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. With both sides requesting it grants the side
// that was not granted last; a lone requester always wins. The pointer moves
// only when the caller accepts the grant.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   req_i,
  input  logic   req_d,
  input  logic   advance,
  output logic   grant_valid,
  output owner_t grant
);

  logic favour_d;

  // Grant selection from the current requests and the fairness pointer.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    grant_valid = req_i | req_d;
    grant       = OWN_I;
    if (req_i && req_d) begin
      grant = favour_d ? OWN_D : OWN_I;
    end else if (req_d) begin
      grant = OWN_D;
    end
  end

  // Pointer favours the side that lost, so the next tie goes the other way.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      favour_d <= 1'b1;
    end else if (advance && grant_valid) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      favour_d <= (grant == OWN_I);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-side fill port and a data-side fill/store port
// onto one backing memory. Each grant runs a fixed-length transfer: a
// request-propagation delay, then line-fill read beats (fills) or a single
// write on the last cycle (stores), with a one-cycle done pulse at the end.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int OUT_CYCLES = DEF_OUT_CYCLES,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic [BEAT_W-1:0] i_beat,
  output logic              i_done,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic [BEAT_W-1:0] d_beat,
  output logic              d_done,
  output logic              busy,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // Last transfer cycle; the transfer occupies cnt = 0..CNT_MAX.
  localparam int CNT_MAX = OUT_CYCLES + LINE_WORDS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  txn_t               txn, txn_next;
  logic               arb_advance;
  logic               grant_valid;
  owner_t             grant;
  logic               last_cycle;
  logic               fill_beat;
  logic [BEAT_W-1:0]  beat;

  rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .reset       (reset),
    .req_i       (i_req),
    .req_d       (d_req),
    .advance     (arb_advance),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // State, cycle counter and latched transaction; reset abandons any transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      txn   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      txn   <= txn_next;
    end
  end

  // Next-state: grant and latch in IDLE, count through XFER, return on the last cycle.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    txn_next    = txn;
    arb_advance = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          arb_advance    = 1'b1;
          txn_next.owner = grant;
          txn_next.we    = (grant == OWN_D) ? d_we : 1'b0;
          txn_next.addr  = (grant == OWN_D) ? d_addr : i_addr;
          txn_next.wdata = (grant == OWN_D) ? d_wdata : 32'h0;
          cnt_next       = '0;
          state_next     = ST_XFER;
        end
      end
      ST_XFER: begin
        if (cnt == CNT_W'(CNT_MAX)) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy       = (state == ST_XFER);
  assign last_cycle = busy && (cnt == CNT_W'(CNT_MAX));
  assign fill_beat  = busy && !txn.we && (cnt >= CNT_W'(OUT_CYCLES))
                      && (cnt < CNT_W'(CNT_MAX));
  assign beat       = BEAT_W'(cnt - CNT_W'(OUT_CYCLES));

  // Command and response decode; everything idles at zero unless driven here.
  always_comb begin
    i_rvalid     = 1'b0;
    i_rdata      = 32'h0;
    i_beat       = '0;
    i_done       = 1'b0;
    d_rvalid     = 1'b0;
    d_rdata      = 32'h0;
    d_beat       = '0;
    d_done       = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
    if (fill_beat) begin
      mem_read_en = 1'b1;
      mem_addr    = line_base(txn.addr, LINE_WORDS) + 32'({beat, 2'b00});
      if (txn.owner == OWN_D) begin
        d_rvalid = 1'b1;
        d_beat   = beat;
        d_rdata  = mem_rdata;
      end else begin
        i_rvalid = 1'b1;
        i_beat   = beat;
        i_rdata  = mem_rdata;
      end
    end
    if (last_cycle) begin
      if (txn.we) begin
        mem_write_en = 1'b1;
        mem_addr     = txn.addr;
        mem_wdata    = txn.wdata;
      end
      if (txn.owner == OWN_D) begin
        d_done = 1'b1;
      end else begin
        i_done = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model with a
// per-cycle compare, directed scenarios with literal expectations, then
// random two-sided traffic.
module tb_mem_arbiter;

  localparam int OUT      = 5;
  localparam int LW       = 4;
  localparam int XFER_LEN = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_rvalid, d_rvalid, i_done, d_done, busy;
  logic [31:0] i_rdata, d_rdata;
  logic [1:0]  i_beat, d_beat;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_beat(i_beat), .i_done(i_done),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_beat(d_beat), .d_done(d_done),
    .busy(busy),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Backing memory contents as a pure function of address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign mem_rdata = mem_read_en ? mem_fn(mem_addr) : 32'h0;

  typedef struct packed {
    logic        busy;
    logic        i_rvalid;
    logic [1:0]  i_beat;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_rvalid;
    logic [1:0]  d_beat;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
  } obs_t;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Snapshot of DUT outputs; read data only meaningful with its valid.
  function automatic obs_t pack_actual();
    obs_t o;
    o.busy = busy;
    o.i_rvalid = i_rvalid; o.i_beat = i_beat; o.i_done = i_done;
    o.i_rdata = i_rvalid ? i_rdata : 32'h0;
    o.d_rvalid = d_rvalid; o.d_beat = d_beat; o.d_done = d_done;
    o.d_rdata = d_rvalid ? d_rdata : 32'h0;
    o.mem_read_en = mem_read_en; o.mem_write_en = mem_write_en;
    o.mem_addr = mem_addr; o.mem_wdata = mem_wdata;
    return o;
  endfunction

  // What cycle k of a granted transaction must look like.
  function automatic obs_t xfer_obs(input bit own_d, input bit we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input int k);
    obs_t o;
    logic [31:0] a;
    o = '0;
    o.busy = 1'b1;
    if (!we && k >= OUT && k < OUT + LW) begin
      a = {addr[31:4], 4'h0} + 32'(4 * (k - OUT));
      o.mem_read_en = 1'b1;
      o.mem_addr = a;
      if (own_d) begin
        o.d_rvalid = 1'b1; o.d_beat = 2'(k - OUT); o.d_rdata = mem_fn(a);
      end else begin
        o.i_rvalid = 1'b1; o.i_beat = 2'(k - OUT); o.i_rdata = mem_fn(a);
      end
    end
    if (k == XFER_LEN - 1) begin
      if (we) begin
        o.mem_write_en = 1'b1; o.mem_addr = addr; o.mem_wdata = wdata;
      end
      if (own_d) o.d_done = 1'b1;
      else       o.i_done = 1'b1;
    end
    return o;
  endfunction

  // Model: queue of expected cycles per granted transaction, fairness bit,
  // and per-side count of other-side completions while waiting.
  obs_t exp_q[$];
  bit   fav_d = 1'b1;
  int   i_wait = 0, d_wait = 0;

  always @(negedge clk) begin : model_cmp
    obs_t e;
    bit   win_d;
    if (reset) begin
      exp_q.delete();
      fav_d  = 1'b1;
      i_wait = 0;
      d_wait = 0;
      e = '0;
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else begin
        e = '0;
        if (i_req || d_req) begin
          win_d = (i_req && d_req) ? fav_d : d_req;
          fav_d = !win_d;
          for (int k = 0; k < XFER_LEN; k++)
            exp_q.push_back(xfer_obs(win_d, win_d ? d_we : 1'b0, win_d ? d_addr : i_addr,
                                     win_d ? d_wdata : 32'h0, k));
        end
      end
      if (d_done && i_req) i_wait++;
      if (i_done && d_req) d_wait++;
      if (i_done) begin check("starve_i", i_wait <= 1, 1); i_wait = 0; end
      if (d_done) begin check("starve_d", d_wait <= 1, 1); d_wait = 0; end
    end
    check("cycle", pack_actual(), e);
    check("rw_overlap", mem_read_en & mem_write_en, 1'b0);
  end

  // Per-transaction log filled by observe().
  int          lg_rd_cyc[$];
  logic [31:0] lg_rd_addr[$];
  int          lg_beat[$];
  int          lg_done_cyc, lg_wr_cyc, lg_wait, lg_i_act;
  bit          lg_done_d;
  logic [31:0] lg_wr_addr, lg_wr_data;

  task automatic drive_d(input bit we, input logic [31:0] a, input logic [31:0] w);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = w;
  endtask

  task automatic drive_i(input logic [31:0] a);
    i_req = 1'b1; i_addr = a;
  endtask

  // Follow one transaction: count IDLE cycles until busy, then log XFER cycle
  // k = 0.. . Optionally raise i_req or assert reset at a given k.
  task automatic observe(input int raise_i_at, input int reset_at);
    lg_rd_cyc.delete(); lg_rd_addr.delete(); lg_beat.delete();
    lg_done_cyc = -1; lg_wr_cyc = -1; lg_wait = 0; lg_i_act = 0; lg_done_d = 1'b0;
    lg_wr_addr = 32'h0; lg_wr_data = 32'h0;
    @(negedge clk);
    while (!busy && lg_wait < 20) begin
      lg_wait++;
      @(negedge clk);
    end
    if (!busy) begin
      check("busy_timeout", busy, 1'b1);
      return;
    end
    for (int k = 0; k < 20; k++) begin
      if (mem_read_en) begin
        lg_rd_cyc.push_back(k);
        lg_rd_addr.push_back(mem_addr);
        lg_beat.push_back(i_rvalid ? int'(i_beat) : int'(d_beat));
      end
      if (mem_write_en) begin
        lg_wr_cyc = k; lg_wr_addr = mem_addr; lg_wr_data = mem_wdata;
      end
      if (i_done || d_done) begin
        lg_done_cyc = k; lg_done_d = d_done;
      end
      if (!lg_done_d || lg_done_cyc < 0) lg_i_act += int'(i_rvalid | i_done);
      if (k == raise_i_at) drive_i(32'h0000_0700);
      if (k == reset_at) begin
        #2;
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
        #1;
        check("reset_mid_outs", pack_actual(), obs_t'(0));
        check("reset_mid_busy", busy, 1'b0);
        return;
      end
      if (lg_done_cyc >= 0) break;
      @(negedge clk);
    end
    if (lg_done_cyc >= 0) begin
      @(posedge clk); #1;
      if (lg_done_d) d_req = 1'b0;
      else           i_req = 1'b0;
    end
  endtask

  initial begin : global_timeout
    #1_000_000;
    failures++;
    $display("FAIL global_timeout t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    int          n_txn, cyc;
    bit          i_fin, d_fin;
    int          exp_addr[4];
    reset = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", pack_actual(), obs_t'(0));
    check("reset_busy", busy, 1'b0);
    reset = 1'b0;

    // Data-side line fill at 0x44: beats from line base 0x40.
    @(posedge clk); #1;
    drive_d(1'b0, 32'h0000_0044, 32'h0);
    observe(-1, -1);
    exp_addr = '{32'h40, 32'h44, 32'h48, 32'h4C};
    check("t036_nreads", lg_rd_cyc.size(), 4);
    if (lg_rd_cyc.size() == 4) begin
      for (int b = 0; b < 4; b++) begin
        check("t036_rd_cyc", lg_rd_cyc[b], 5 + b);
        check("t036_rd_addr", lg_rd_addr[b], exp_addr[b]);
        check("t036_beat", lg_beat[b], b);
      end
    end
    check("t036_done_cyc", lg_done_cyc, 9);
    check("t036_done_d", lg_done_d, 1'b1);
    check("t036_no_write", lg_wr_cyc, -1);

    // Data-side store.
    @(posedge clk); #1;
    drive_d(1'b1, 32'h0000_0100, 32'hCAFE_F00D);
    observe(-1, -1);
    check("t037_nreads", lg_rd_cyc.size(), 0);
    check("t037_wr_cyc", lg_wr_cyc, 9);
    check("t037_wr_addr", lg_wr_addr, 32'h0000_0100);
    check("t037_wr_data", lg_wr_data, 32'hCAFE_F00D);
    check("t037_done_cyc", lg_done_cyc, 9);
    check("t037_done_d", lg_done_d, 1'b1);

    // Round robin from reset: tie -> D then I; D alone; tie again -> I then D.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    drive_i(32'h0000_0200);
    drive_d(1'b0, 32'h0000_0300, 32'h0);
    observe(-1, -1);
    check("t038_first_d", lg_done_d, 1'b1);
    observe(-1, -1);
    check("t038_then_i", lg_done_d, 1'b0);
    if (lg_rd_addr.size() > 0) check("t038_i_addr", lg_rd_addr[0], 32'h0000_0200);
    @(posedge clk); #1;
    drive_d(1'b0, 32'h0000_0380, 32'h0);
    observe(-1, -1);
    check("t038_d_alone", lg_done_d, 1'b1);
    @(posedge clk); #1;
    drive_i(32'h0000_0400);
    drive_d(1'b0, 32'h0000_0500, 32'h0);
    observe(-1, -1);
    check("t038_tie2_i", lg_done_d, 1'b0);
    observe(-1, -1);
    check("t038_tie2_d", lg_done_d, 1'b1);

    // I request arriving during a D transfer waits for the next IDLE.
    @(posedge clk); #1;
    drive_d(1'b1, 32'h0000_0600, 32'h1234_5678);
    observe(3, -1);
    check("t039_d_done", lg_done_d, 1'b1);
    check("t039_no_i_act", lg_i_act, 0);
    observe(-1, -1);
    check("t039_i_wait", lg_wait, 1);
    check("t039_i_done", lg_done_d, 1'b0);
    if (lg_rd_addr.size() > 0) check("t039_i_addr", lg_rd_addr[0], 32'h0000_0700);

    // Reset during a store at cycle 7: no write, no done.
    @(posedge clk); #1;
    drive_d(1'b1, 32'h0000_0800, 32'hDEAD_BEEF);
    observe(-1, 7);
    check("t040_no_done", lg_done_cyc, -1);
    repeat (3) begin
      @(negedge clk);
      check("t040_no_write", mem_write_en, 1'b0);
      check("t040_no_done_d", d_done, 1'b0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // Random traffic: each side raises requests at will, drops on done.
    n_txn = 0;
    cyc = 0;
    while (n_txn < 1000 && cyc < 30000) begin
      @(negedge clk);
      i_fin = i_done;
      d_fin = d_done;
      @(posedge clk); #1;
      cyc++;
      if (i_fin) begin
        i_req = 1'b0; n_txn++;
      end else if (!i_req && $urandom_range(3) == 0) begin
        drive_i($urandom);
      end
      if (d_fin) begin
        d_req = 1'b0; n_txn++;
      end else if (!d_req && $urandom_range(3) == 0) begin
        drive_d(1'($urandom_range(1)), $urandom, $urandom);
      end
    end
    check("random_txn_count", n_txn >= 1000, 1'b1);
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (15) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
